// File: rtl/vga_fb_scanout.sv
// Framebuffer scan-out engine: 640x480@60 raster timing, one BRAM read per visible pixel,
// hs/vs delayed to stay aligned with the registered rgb after the BRAM read latency.
module vga_fb_scanout #(
  parameter int unsigned H_VIS  = 640,
  parameter int unsigned H_FP   = 16,
  parameter int unsigned H_SYNC = 96,
  parameter int unsigned H_BP   = 48,
  parameter int unsigned V_VIS  = 480,
  parameter int unsigned V_FP   = 10,
  parameter int unsigned V_SYNC = 2,
  parameter int unsigned V_BP   = 33,
  parameter int unsigned RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [18:0] fb_base,
  output logic [18:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  output logic        hs,
  output logic        vs,
  output logic [11:0] rgb,
  output logic        vblank,
  output logic        frame_start
);

  localparam int unsigned H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);
  localparam int unsigned VD    = RD_LAT + 1;
  localparam int unsigned SD    = RD_LAT + 2;

  localparam logic [HW-1:0] H_VIS_C  = HW'(H_VIS);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_VIS_C  = VW'(V_VIS);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SYNC - 1);

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [18:0]   addr_cnt_q, addr_cnt_d;
  logic [18:0]   mem_addr_q, mem_addr_d;
  logic          mem_rd_q, mem_rd_d;
  logic [VD-1:0] vis_pipe_q, vis_pipe_d;
  logic [SD-1:0] hs_pipe_q, hs_pipe_d;
  logic [SD-1:0] vs_pipe_q, vs_pipe_d;
  logic [11:0]   rgb_q, rgb_d;
  logic          vblank_q, vblank_d;
  logic          frame_start_q, frame_start_d;

  logic          visible;
  logic          h_wrap;
  logic          frame_wrap;
  logic          unused_data;

  assign unused_data = ^mem_data[15:12];

  always_comb begin
    visible    = (h_cnt_q < H_VIS_C) && (v_cnt_q < V_VIS_C);
    h_wrap     = (h_cnt_q == H_LAST);
    frame_wrap = h_wrap && (v_cnt_q == V_LAST);

    h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end

    // addr_cnt carries base + v*H_VIS + h; the frame wrap is never visible, so the two cases are exclusive
    addr_cnt_d = addr_cnt_q;
    if (frame_wrap) begin
      addr_cnt_d = fb_base;
    end else if (visible) begin
      addr_cnt_d = addr_cnt_q + 19'd1;
    end

    mem_addr_d = visible ? addr_cnt_q : mem_addr_q;
    mem_rd_d   = visible;

    vis_pipe_d = {vis_pipe_q[VD-2:0], visible};
    hs_pipe_d  = {hs_pipe_q[SD-2:0], ~((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END))};
    vs_pipe_d  = {vs_pipe_q[SD-2:0], ~((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END))};

    rgb_d = vis_pipe_q[VD-1] ? mem_data[11:0] : '0;

    vblank_d      = (v_cnt_q >= V_VIS_C);
    frame_start_d = frame_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      addr_cnt_q    <= '0;
      mem_addr_q    <= '0;
      mem_rd_q      <= 1'b0;
      vis_pipe_q    <= '0;
      hs_pipe_q     <= '1;
      vs_pipe_q     <= '1;
      rgb_q         <= '0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      addr_cnt_q    <= addr_cnt_d;
      mem_addr_q    <= mem_addr_d;
      mem_rd_q      <= mem_rd_d;
      vis_pipe_q    <= vis_pipe_d;
      hs_pipe_q     <= hs_pipe_d;
      vs_pipe_q     <= vs_pipe_d;
      rgb_q         <= rgb_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign mem_addr    = mem_addr_q;
  assign mem_rd      = mem_rd_q;
  assign hs          = hs_pipe_q[SD-1];
  assign vs          = vs_pipe_q[SD-1];
  assign rgb         = rgb_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Bench for vga_fb_scanout: full horizontal timing with a shortened frame height, BRAM model,
// cycle scoreboard, a table of timing/address checkpoints and hand-written reset sequences.
module tb_vga_fb_scanout;

  localparam int unsigned H_VIS  = 640;
  localparam int unsigned H_FP   = 16;
  localparam int unsigned H_SYNC = 96;
  localparam int unsigned H_BP   = 48;
  localparam int unsigned V_VIS  = 6;
  localparam int unsigned V_FP   = 2;
  localparam int unsigned V_SYNC = 2;
  localparam int unsigned V_BP   = 3;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int unsigned FRAME  = H_TOT * V_TOT;
  localparam int unsigned HSF    = H_VIS + H_FP + RD_LAT + 2;
  localparam int unsigned VSF    = (V_VIS + V_FP) * H_TOT + RD_LAT + 2;
  localparam int unsigned NV     = 30;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] fb_base = 19'h11111;
  logic [18:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_data;
  logic        hs, vs, vblank, frame_start;
  logic [11:0] rgb;
  logic        force_ff = 1'b0;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned ecount = 0;

  typedef struct { int unsigned due; logic [21:0] v; } item_t;
  typedef struct { string name; int unsigned cyc; int unsigned sel; logic [18:0] val; } vec_t;
  item_t qf[$];
  item_t qs[$];
  vec_t  vecs [NV];

  vga_fb_scanout #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .fb_base(fb_base),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .hs(hs), .vs(vs), .rgb(rgb), .vblank(vblank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_fn(input logic [18:0] a);
    return {4'hA, a[11:0] ^ {5'b0, a[18:12]}};
  endfunction

  // BRAM with one clock of read latency from the registered address
  always @(posedge clk) mem_data <= force_ff ? 16'hFFFF : mem_fn(mem_addr);

  task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, ecount, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd"}, {21'b0, mem_rd}, 22'd0);
    check({tag, "_mem_addr"}, {3'b0, mem_addr}, 22'd0);
    check({tag, "_hs"}, {21'b0, hs}, 22'd1);
    check({tag, "_vs"}, {21'b0, vs}, 22'd1);
    check({tag, "_rgb"}, {10'b0, rgb}, 22'd0);
    check({tag, "_vblank"}, {21'b0, vblank}, 22'd0);
    check({tag, "_frame_start"}, {21'b0, frame_start}, 22'd0);
  endtask

  task automatic goto(input int unsigned target);
    int unsigned g;
    g = 0;
    while (ecount < target) begin
      @(posedge clk);
      #2;
      g++;
      if (g > 60000) begin
        $display("FAIL goto_timeout: reached cycle %0d, required %0d", ecount, target);
        $fatal(1);
      end
    end
  endtask

  // Reference raster model: pushes expected outputs with the cycle they are due
  initial begin : model_p
    int unsigned mh, mv;
    logic [18:0] maddr, last;
    logic        vis, fs, hs_e, vs_e;
    logic [15:0] w;
    logic [11:0] rgb_e;
    mh = 0; mv = 0; maddr = '0; last = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mh = 0; mv = 0; maddr = '0; last = '0; ecount = 0;
        qf.delete();
        qs.delete();
        for (int unsigned d = 1; d <= RD_LAT + 1; d++) qs.push_back('{d, 22'h003000});
      end else begin
        ecount++;
        vis = (mh < H_VIS) && (mv < V_VIS);
        if (vis) last = maddr;
        fs = (mh == H_TOT - 1) && (mv == V_TOT - 1);
        qf.push_back('{ecount, {vis, last, (mv >= V_VIS), fs}});
        hs_e = !((mh >= H_VIS + H_FP) && (mh < H_VIS + H_FP + H_SYNC));
        vs_e = !((mv >= V_VIS + V_FP) && (mv < V_VIS + V_FP + V_SYNC));
        w = mem_fn(maddr);
        rgb_e = !vis ? 12'h000 : (force_ff ? 12'hFFF : w[11:0]);
        qs.push_back('{ecount + RD_LAT + 1, {8'b0, hs_e, vs_e, rgb_e}});
        if (fs) maddr = fb_base;
        else if (vis) maddr = maddr + 19'd1;
        if (mh == H_TOT - 1) begin
          mh = 0;
          mv = (mv == V_TOT - 1) ? 0 : mv + 1;
        end else begin
          mh++;
        end
      end
    end
  end

  initial begin : checker_p
    item_t it;
    logic [21:0] act;
    forever begin
      @(negedge clk);
      if (!rst && ecount > 0) begin
        while (qf.size() > 0 && qf[0].due <= ecount) begin
          it = qf.pop_front();
          check("scan_rd_addr_status", {mem_rd, mem_addr, vblank, frame_start}, it.v);
        end
        while (qs.size() > 0 && qs[0].due <= ecount) begin
          it = qs.pop_front();
          check("scan_sync_rgb", {8'b0, hs, vs, rgb}, it.v);
        end
        for (int i = 0; i < NV; i++) begin
          if (vecs[i].cyc == ecount) begin
            case (vecs[i].sel)
              0:       act = {3'b0, mem_addr};
              1:       act = {21'b0, mem_rd};
              2:       act = {21'b0, hs};
              3:       act = {21'b0, vs};
              4:       act = {21'b0, vblank};
              5:       act = {21'b0, frame_start};
              default: act = {10'b0, rgb};
            endcase
            check(vecs[i].name, act, {3'b0, vecs[i].val});
          end
        end
      end
    end
  end

  initial begin : main_p
    vecs[0]  = '{"rel_addr0",     1,                                  0, 19'd0};
    vecs[1]  = '{"rel_rd1",       1,                                  1, 19'd1};
    vecs[2]  = '{"rd_last_vis",   H_VIS,                              1, 19'd1};
    vecs[3]  = '{"rd_blank_first", H_VIS + 1,                         1, 19'd0};
    vecs[4]  = '{"rd_blank_last", H_TOT,                              1, 19'd0};
    vecs[5]  = '{"rd_line1",      H_TOT + 1,                          1, 19'd1};
    vecs[6]  = '{"hs_before",     HSF - 1,                            2, 19'd1};
    vecs[7]  = '{"hs_fall",       HSF,                                2, 19'd0};
    vecs[8]  = '{"hs_last_low",   HSF + H_SYNC - 1,                   2, 19'd0};
    vecs[9]  = '{"hs_rise",       HSF + H_SYNC,                       2, 19'd1};
    vecs[10] = '{"vs_before",     VSF - 1,                            3, 19'd1};
    vecs[11] = '{"vs_fall",       VSF,                                3, 19'd0};
    vecs[12] = '{"vs_last_low",   VSF + V_SYNC * H_TOT - 1,           3, 19'd0};
    vecs[13] = '{"vs_rise",       VSF + V_SYNC * H_TOT,               3, 19'd1};
    vecs[14] = '{"vblank_off",    V_VIS * H_TOT,                      4, 19'd0};
    vecs[15] = '{"vblank_on",     V_VIS * H_TOT + 1,                  4, 19'd1};
    vecs[16] = '{"fs_pre",        FRAME - 1,                          5, 19'd0};
    vecs[17] = '{"fs_1",          FRAME,                              5, 19'd1};
    vecs[18] = '{"fs_post",       FRAME + 1,                          5, 19'd0};
    vecs[19] = '{"fs_2",          2 * FRAME,                          5, 19'd1};
    vecs[20] = '{"f0_last_addr",  (V_VIS - 1) * H_TOT + H_VIS,        0, 19'(V_VIS * H_VIS - 1)};
    vecs[21] = '{"f1_first_addr", FRAME + 1,                          0, 19'h4B000};
    vecs[22] = '{"f1_last_addr",  FRAME + (V_VIS - 1) * H_TOT + H_VIS, 0, 19'h4B000 + 19'(V_VIS * H_VIS - 1)};
    vecs[23] = '{"f2_addr_7ffff", 2 * FRAME + 1,                      0, 19'h7FFFF};
    vecs[24] = '{"f2_addr_wrap0", 2 * FRAME + 2,                      0, 19'h00000};
    vecs[25] = '{"f2_addr_wrap1", 2 * FRAME + 3,                      0, 19'h00001};
    vecs[26] = '{"rgb_pipe_empty", RD_LAT + 1,                        6, 19'd0};
    vecs[27] = '{"rgb_pix5",      RD_LAT + 7,                         6, 19'h005};
    vecs[28] = '{"rgb_vis_ffff",  2 * H_TOT + 100 + RD_LAT + 2,       6, 19'hFFF};
    vecs[29] = '{"rgb_blank_ffff", 2 * H_TOT + H_VIS + RD_LAT + 2,    6, 19'h000};

    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("hold_rst");
    rst = 1'b0;

    // force all-ones data for line 2, toggled only inside horizontal blanking
    goto(H_TOT + 700);
    force_ff = 1'b1;
    goto(2 * H_TOT + 700);
    force_ff = 1'b0;

    goto(3000);
    fb_base = 19'h4B000;
    goto(FRAME + 3000);
    fb_base = 19'h7FFFF;

    goto(2 * FRAME + 3 * H_TOT + 100);
    check({21'b0, mem_rd}, 22'd1, 22'd1) ;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    repeat (3) @(posedge clk);
    #2;
    check_reset_outputs("mid_rst_hold");
    rst = 1'b0;

    goto(2 * H_TOT + 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
